// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator with a 2-entry skid buffer on a valid/ready interface.
// Optional CSR-immediate (fmt Z) decode enabled by defining IMM_GEN_PIPE_CSR_EN.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_instr,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [XLEN-1:0]  o_imm,
  output logic [2:0]       o_fmt,
  output logic             o_illegal,
  output logic [TAG_W-1:0] o_tag
);

  localparam int unsigned SH_W = (XLEN == 64) ? 6 : 5;

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_SH   = 3'd6;
`ifdef IMM_GEN_PIPE_CSR_EN
  localparam logic [2:0] FMT_Z    = 3'd7;
`endif

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              ready_q, valid_q;
  logic [XLEN-1:0]   main_imm_q, skid_imm_q;
  logic [2:0]        main_fmt_q, skid_fmt_q;
  logic              main_ill_q, skid_ill_q;
  logic [TAG_W-1:0]  main_tag_q, skid_tag_q;

  logic [XLEN-1:0]   dec_imm_c;
  logic [2:0]        dec_fmt_c;
  logic              dec_ill_c;
  logic              in_fire_c, out_fire_c;
  logic              load_main_c, load_skid_c, main_from_skid_c;

  // Combinational immediate decode of the incoming instruction
  always_comb begin
    logic [6:0] opcode;
    logic [2:0] funct3;
    opcode    = i_instr[6:0];
    funct3    = i_instr[14:12];
    dec_imm_c = '0;
    dec_fmt_c = FMT_NONE;
    dec_ill_c = 1'b0;
    if (i_instr[1:0] != 2'b11) begin
      dec_ill_c = 1'b1;
    end else begin
      case (opcode)
        7'b0010011: begin
          if (funct3 == 3'b001 || funct3 == 3'b101) begin
            dec_fmt_c = FMT_SH;
            dec_imm_c = XLEN'(i_instr[20 +: SH_W]);
          end else begin
            dec_fmt_c = FMT_I;
            dec_imm_c = XLEN'($signed(i_instr[31:20]));
          end
        end
        7'b0000011, 7'b1100111: begin
          dec_fmt_c = FMT_I;
          dec_imm_c = XLEN'($signed(i_instr[31:20]));
        end
        7'b0100011: begin
          dec_fmt_c = FMT_S;
          dec_imm_c = XLEN'($signed({i_instr[31:25], i_instr[11:7]}));
        end
        7'b1100011: begin
          dec_fmt_c = FMT_B;
          dec_imm_c = XLEN'($signed({i_instr[31], i_instr[7], i_instr[30:25],
                                     i_instr[11:8], 1'b0}));
        end
        7'b0110111, 7'b0010111: begin
          dec_fmt_c = FMT_U;
          dec_imm_c = XLEN'($signed({i_instr[31:12], 12'b0}));
        end
        7'b1101111: begin
          dec_fmt_c = FMT_J;
          dec_imm_c = XLEN'($signed({i_instr[31], i_instr[19:12], i_instr[20],
                                     i_instr[30:21], 1'b0}));
        end
        7'b1110011: begin
`ifdef IMM_GEN_PIPE_CSR_EN
          if (funct3[2] && funct3[1:0] != 2'b00) begin
            dec_fmt_c = FMT_Z;
            dec_imm_c = XLEN'(i_instr[19:15]);
          end
`endif
        end
        7'b0110011, 7'b0001111: begin
          dec_fmt_c = FMT_NONE;
        end
        default: dec_ill_c = 1'b1;
      endcase
    end
  end

  assign in_fire_c  = i_valid & ready_q;
  assign out_fire_c = valid_q & i_ready;

  // Skid buffer next-state; flush wins over every transition
  always_comb begin
    state_d          = state_q;
    load_main_c      = 1'b0;
    load_skid_c      = 1'b0;
    main_from_skid_c = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire_c) begin
          state_d     = ST_ONE;
          load_main_c = 1'b1;
        end
      end
      ST_ONE: begin
        if (in_fire_c && out_fire_c) begin
          load_main_c = 1'b1;
        end else if (out_fire_c) begin
          state_d = ST_EMPTY;
        end else if (in_fire_c) begin
          state_d     = ST_FULL;
          load_skid_c = 1'b1;
        end
      end
      ST_FULL: begin
        if (out_fire_c) begin
          state_d          = ST_ONE;
          main_from_skid_c = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (i_flush) begin
      state_d          = ST_EMPTY;
      load_main_c      = 1'b0;
      load_skid_c      = 1'b0;
      main_from_skid_c = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_EMPTY;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      main_imm_q <= '0;
      main_fmt_q <= '0;
      main_ill_q <= 1'b0;
      main_tag_q <= '0;
      skid_imm_q <= '0;
      skid_fmt_q <= '0;
      skid_ill_q <= 1'b0;
      skid_tag_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != ST_FULL);
      valid_q <= (state_d != ST_EMPTY);
      if (load_main_c) begin
        main_imm_q <= dec_imm_c;
        main_fmt_q <= dec_fmt_c;
        main_ill_q <= dec_ill_c;
        main_tag_q <= i_tag;
      end else if (main_from_skid_c) begin
        main_imm_q <= skid_imm_q;
        main_fmt_q <= skid_fmt_q;
        main_ill_q <= skid_ill_q;
        main_tag_q <= skid_tag_q;
      end
      if (load_skid_c) begin
        skid_imm_q <= dec_imm_c;
        skid_fmt_q <= dec_fmt_c;
        skid_ill_q <= dec_ill_c;
        skid_tag_q <= i_tag;
      end
    end
  end

  assign o_ready   = ready_q;
  assign o_valid   = valid_q;
  assign o_imm     = main_imm_q;
  assign o_fmt     = main_fmt_q;
  assign o_illegal = main_ill_q;
  assign o_tag     = main_tag_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: directed test-plan vectors plus randomized traffic
// against a queue-based reference model of decode and FIFO ordering.
module tb_imm_gen_pipe;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 32;

  logic             i_clk = 1'b0;
  logic             i_reset, i_flush, i_valid, i_ready;
  logic [31:0]      i_instr;
  logic [TAG_W-1:0] i_tag;
  logic             o_ready, o_valid, o_illegal;
  logic [XLEN-1:0]  o_imm;
  logic [2:0]       o_fmt;
  logic [TAG_W-1:0] o_tag;

  imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush), .i_valid(i_valid),
    .o_ready(o_ready), .i_instr(i_instr), .i_tag(i_tag), .o_valid(o_valid),
    .i_ready(i_ready), .o_imm(o_imm), .o_fmt(o_fmt), .o_illegal(o_illegal),
    .o_tag(o_tag)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic longint sext(input longint x, input int bits);
    if (x >= (longint'(1) << (bits - 1))) return x - (longint'(1) << bits);
    return x;
  endfunction

  // Reference decode written directly from the field-assembly rules
  function automatic ent_t model(input logic [31:0] ins, input logic [TAG_W-1:0] tag);
    ent_t   e;
    longint v;
    longint w;
    int     op, f3;
    w  = longint'(ins);
    op = int'(w % 128);
    f3 = int'((w / 4096) % 8);
    v  = 0;
    e.tag = tag;
    e.fmt = 3'd0;
    e.ill = 1'b0;
    if ((w % 4) != 3) e.ill = 1'b1;
    else if (op == 'h13 && (f3 == 1 || f3 == 5)) begin
      e.fmt = 3'd6;
      v = (w / (1 << 20)) % ((XLEN == 64) ? 64 : 32);
    end else if (op == 'h13 || op == 'h03 || op == 'h67) begin
      e.fmt = 3'd1;
      v = sext((w / (1 << 20)) % 4096, 12);
    end else if (op == 'h23) begin
      e.fmt = 3'd2;
      v = sext(((w / (1 << 25)) % 128) * 32 + (w / 128) % 32, 12);
    end else if (op == 'h63) begin
      e.fmt = 3'd3;
      v = sext(((w >> 31) & 1) * 4096 + ((w >> 7) & 1) * 2048 +
               ((w >> 25) & 63) * 32 + ((w >> 8) & 15) * 2, 13);
    end else if (op == 'h37 || op == 'h17) begin
      e.fmt = 3'd4;
      v = sext((w >> 12) * 4096, 32);
    end else if (op == 'h6F) begin
      e.fmt = 3'd5;
      v = sext(((w >> 31) & 1) * (1 << 20) + ((w >> 12) & 255) * 4096 +
               ((w >> 20) & 1) * 2048 + ((w >> 21) & 1023) * 2, 21);
    end else if (op == 'h73) begin
`ifdef IMM_GEN_PIPE_CSR_EN
      if (f3 >= 5) begin
        e.fmt = 3'd7;
        v = (w >> 15) & 31;
      end
`endif
    end else if (op == 'h33 || op == 'h0F) begin
      e.fmt = 3'd0;
    end else e.ill = 1'b1;
    e.imm = XLEN'(v);
    return e;
  endfunction

  // Drive one cycle of inputs, advance the clock and update the reference model
  task automatic step(input logic v, input logic [31:0] ins, input logic [TAG_W-1:0] tag,
                      input logic rdy, input logic fl, input logic rst);
    logic m_ready, m_valid;
    i_valid = v; i_instr = ins; i_tag = tag; i_ready = rdy; i_flush = fl; i_reset = rst;
    @(posedge i_clk);
    m_ready = (q.size() < 2);
    m_valid = (q.size() > 0);
    if (rst || fl) q.delete();
    else begin
      if (m_valid && rdy) void'(q.pop_front());
      if (v && m_ready) q.push_back(model(ins, tag));
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 32'hFFF00093, 32'h55, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({o_valid, o_ready, o_imm, o_fmt, o_illegal, o_tag} !== {1'b0, 1'b1, {(XLEN+TAG_W+4){1'b0}}}) begin
      errors++;
      $display("FAIL reset: valid=%b ready=%b imm=%h fmt=%0d ill=%b tag=%h, want 0/1/0/0/0/0",
               o_valid, o_ready, o_imm, o_fmt, o_illegal, o_tag);
    end
  endtask

  task automatic test_decode();
    logic [31:0]     ins  [7];
    logic [XLEN-1:0] eimm [7];
    logic [2:0]      efmt [7];
    logic            eill [7];
    ins[0] = 32'hFFF00093; eimm[0] = '1;             efmt[0] = 3'd1; eill[0] = 1'b0;
    ins[1] = 32'hFE000EE3; eimm[1] = XLEN'(-64'sd4);  efmt[1] = 3'd3; eill[1] = 1'b0;
    ins[2] = 32'h01F09093; eimm[2] = XLEN'(32'h1F);   efmt[2] = 3'd6; eill[2] = 1'b0;
    ins[3] = 32'h4030D093; eimm[3] = XLEN'(32'h3);    efmt[3] = 3'd6; eill[3] = 1'b0;
    ins[4] = 32'h0000007F; eimm[4] = '0;             efmt[4] = 3'd0; eill[4] = 1'b1;
    ins[5] = 32'h00000010; eimm[5] = '0;             efmt[5] = 3'd0; eill[5] = 1'b1;
`ifdef IMM_GEN_PIPE_CSR_EN
    ins[6] = 32'h3002D073; eimm[6] = XLEN'(32'h5);    efmt[6] = 3'd7; eill[6] = 1'b0;
`else
    ins[6] = 32'h3002D073; eimm[6] = '0;             efmt[6] = 3'd0; eill[6] = 1'b0;
`endif
    for (int i = 0; i < 7; i++) begin
      step(1'b1, ins[i], TAG_W'(32'h100 + i), 1'b1, 1'b0, 1'b0);
      checks++;
      if ({o_valid, o_imm, o_fmt, o_illegal, o_tag} !==
          {1'b1, eimm[i], efmt[i], eill[i], TAG_W'(32'h100 + i)}) begin
        errors++;
        $display("FAIL decode[%0d] %h: valid=%b imm=%h fmt=%0d ill=%b tag=%h, want imm=%h fmt=%0d ill=%b",
                 i, ins[i], o_valid, o_imm, o_fmt, o_illegal, o_tag, eimm[i], efmt[i], eill[i]);
      end
    end
    step(1'b0, 32'h0, '0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL decode_drain: valid=%b want 0", o_valid);
    end
  endtask

  task automatic test_backpressure();
    step(1'b1, 32'h12345037, 32'hA, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0080006F, 32'hB, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({o_ready, o_valid, o_imm, o_fmt} !== {1'b0, 1'b1, XLEN'(32'h12345000), 3'd4}) begin
      errors++;
      $display("FAIL bp_full: ready=%b valid=%b imm=%h fmt=%0d, want 0/1/12345000/4",
               o_ready, o_valid, o_imm, o_fmt);
    end
    step(1'b1, 32'h00500093, 32'hC, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({o_ready, o_imm, o_tag} !== {1'b0, XLEN'(32'h12345000), TAG_W'(32'hA)}) begin
      errors++;
      $display("FAIL bp_hold: ready=%b imm=%h tag=%h, want 0/12345000/a", o_ready, o_imm, o_tag);
    end
    step(1'b1, 32'h00500093, 32'hC, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({o_ready, o_valid, o_imm, o_fmt, o_tag} !== {1'b1, 1'b1, XLEN'(32'h8), 3'd5, TAG_W'(32'hB)}) begin
      errors++;
      $display("FAIL bp_second: ready=%b valid=%b imm=%h fmt=%0d tag=%h, want 1/1/8/5/b",
               o_ready, o_valid, o_imm, o_fmt, o_tag);
    end
    step(1'b1, 32'h00500093, 32'hC, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({o_valid, o_imm, o_fmt, o_tag} !== {1'b1, XLEN'(32'h5), 3'd1, TAG_W'(32'hC)}) begin
      errors++;
      $display("FAIL bp_third: valid=%b imm=%h fmt=%0d tag=%h, want 1/5/1/c",
               o_valid, o_imm, o_fmt, o_tag);
    end
    step(1'b0, 32'h0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_flush();
    step(1'b1, 32'h00100093, 32'h1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h00200093, 32'h2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h00300093, 32'h3, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({o_valid, o_ready} !== 2'b01) begin
      errors++;
      $display("FAIL flush_full: valid=%b ready=%b, want 0/1", o_valid, o_ready);
    end
    step(1'b0, 32'h0, '0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_discard: valid=%b tag=%h, want valid 0", o_valid, o_tag);
    end
  endtask

  task automatic test_reset_full();
    step(1'b1, 32'h12345037, 32'h7, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0000007F, 32'h8, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hFFF00093, 32'h9, 1'b0, 1'b1, 1'b1);
    checks++;
    if ({o_valid, o_ready, o_imm, o_fmt, o_illegal, o_tag} !== {1'b0, 1'b1, {(XLEN+TAG_W+4){1'b0}}}) begin
      errors++;
      $display("FAIL reset_full: valid=%b ready=%b imm=%h fmt=%0d ill=%b tag=%h, want all zero, ready 1",
               o_valid, o_ready, o_imm, o_fmt, o_illegal, o_tag);
    end
  endtask

  task automatic test_random();
    logic [6:0] ops [12];
    logic [31:0] ins;
    ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h0F, 7'h73, 7'h7F};
    for (int c = 0; c < 400; c++) begin
      ins = $urandom;
      if ($urandom_range(7) != 0) ins[6:0] = ops[$urandom_range(11)];
      step(1'($urandom_range(1)), ins, TAG_W'($urandom), 1'($urandom_range(2) != 0),
           1'($urandom_range(31) == 0), 1'b0);
      checks++;
      if ({o_valid, o_ready} !== {1'(q.size() > 0), 1'(q.size() < 2)}) begin
        errors++;
        $display("FAIL rand_hs[%0d]: valid=%b ready=%b, want %b/%b", c, o_valid, o_ready,
                 q.size() > 0, q.size() < 2);
      end
      if (q.size() > 0) begin
        checks++;
        if ({o_imm, o_fmt, o_illegal, o_tag} !== q[0]) begin
          errors++;
          $display("FAIL rand_data[%0d]: imm=%h fmt=%0d ill=%b tag=%h, want imm=%h fmt=%0d ill=%b tag=%h",
                   c, o_imm, o_fmt, o_illegal, o_tag, q[0].imm, q[0].fmt, q[0].ill, q[0].tag);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_backpressure();
    test_flush();
    test_reset_full();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
